// File: rtl/mystery_ship_ctrl_if.sv
// Signal bundle between the mystery ship controller and its neighbours
// (pixel scan, spaceship laser, score keeper). clk/rst stay plain ports.
interface mystery_ship_ctrl_if #(
   parameter int X_WIDTH = 11
);
   logic               i_restart;
   logic               i_game_active;
   logic               i_frame_tick;
   logic [X_WIDTH-1:0] i_xCoord;
   logic [X_WIDTH-1:0] i_yCoord;
   logic               i_laser_valid;
   logic [X_WIDTH-1:0] i_laser_x;
   logic [X_WIDTH-1:0] i_laser_y;
   logic               o_hit;
   logic [8:0]         o_score_value;
   logic [X_WIDTH-1:0] o_center_x;
   logic [X_WIDTH-1:0] o_center_y;
   logic               o_is_ship;
   logic [7:0]         o_rgb;
   logic [1:0]         o_state;

   modport slave (
      input  i_restart, i_game_active, i_frame_tick, i_xCoord, i_yCoord,
             i_laser_valid, i_laser_x, i_laser_y,
      output o_hit, o_score_value, o_center_x, o_center_y, o_is_ship, o_rgb, o_state
   );

   modport master (
      output i_restart, i_game_active, i_frame_tick, i_xCoord, i_yCoord,
             i_laser_valid, i_laser_x, i_laser_y,
      input  o_hit, o_score_value, o_center_x, o_center_y, o_is_ship, o_rgb, o_state
   );
endinterface

// File: rtl/mystery_ship_ctrl.sv
// Bonus ship crossing the top of the playfield in alternating directions.
// Optional macro MYSTERY_SHIP_RANDOM_WAIT_EN adds an LFSR-based extra idle wait.
module mystery_ship_ctrl #(
   parameter int          X_WIDTH        = 11,
   parameter int          SCREEN_WIDTH   = 640,
   parameter int          MARGIN         = 50,
   parameter int          SHIP_LENGTH    = 40,
   parameter int          SHIP_TOP       = 50,
   parameter int          SHIP_HEIGHT    = 16,
   parameter int          SPEED_DIV      = 3,
   parameter int          WAIT_FRAMES    = 25,
   parameter int          EXPLODE_FRAMES = 30,
   parameter logic [7:0]  COLOR_SHIP     = 8'hA7,
   parameter logic [7:0]  COLOR_EXPLODE  = 8'h3F
) (
   input logic                clk,
   input logic                rst,
   mystery_ship_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, FLY = 2'd1, EXPLODE = 2'd2} state_t;

   localparam int              CMP_W  = X_WIDTH + 2;
   localparam int              HALF   = SHIP_LENGTH / 2;
   localparam logic [X_WIDTH-1:0] X_FAR = X_WIDTH'(SCREEN_WIDTH + 2 * MARGIN);

   state_t             r_state, w_nextState;
   logic [15:0]        r_waitCnt, r_explodeCnt, r_divCnt;
   logic               r_dir;
   logic [X_WIDTH-1:0] r_xPos;
   logic               r_hit;
   logic [8:0]         r_score;
   logic [7:0]         r_lfsr;
   logic [15:0]        w_waitTarget;
   logic               w_syncReset, w_tick, w_waitDone, w_divWrap, w_exitStep;
   logic               w_explodeDone, w_hitDet, w_scanInBox, w_visible;
   logic [X_WIDTH-1:0] w_nextX;
   logic [7:0]         w_lfsrNext;
   logic [8:0]         w_scoreNext;

   // Box test shared by the laser and the pixel scan; widened so no sum wraps.
   function automatic logic inBox(input logic [X_WIDTH-1:0] px, input logic [X_WIDTH-1:0] py,
                                  input logic [X_WIDTH-1:0] cx);
      logic [CMP_W-1:0] x, y, c;
      x = CMP_W'(px);
      y = CMP_W'(py);
      c = CMP_W'(cx);
      return (x + CMP_W'(MARGIN + HALF) >= c) && (x + CMP_W'(MARGIN) <= c + CMP_W'(HALF)) &&
             (y >= CMP_W'(SHIP_TOP)) && (y <= CMP_W'(SHIP_TOP + SHIP_HEIGHT - 1));
   endfunction

   assign w_syncReset   = bus.i_restart | ~bus.i_game_active;
   assign w_tick        = bus.i_frame_tick;
   assign w_lfsrNext    = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
   assign w_waitDone    = w_tick && ((r_waitCnt + 16'd1) == w_waitTarget);
   assign w_divWrap     = w_tick && (r_divCnt == 16'(SPEED_DIV - 1));
   assign w_nextX       = r_dir ? r_xPos + 1'b1 : r_xPos - 1'b1;
   assign w_exitStep    = w_divWrap && (w_nextX == (r_dir ? X_FAR : '0));
   assign w_explodeDone = w_tick && ((r_explodeCnt + 16'd1) == 16'(EXPLODE_FRAMES));
   assign w_hitDet      = (r_state == FLY) && bus.i_laser_valid &&
                          inBox(bus.i_laser_x, bus.i_laser_y, r_xPos);
   assign w_scanInBox   = inBox(bus.i_xCoord, bus.i_yCoord, r_xPos);
   assign w_visible     = (32'(bus.i_xCoord) < SCREEN_WIDTH) && (32'(bus.i_yCoord) < 480);

   always_comb begin
      w_scoreNext = 9'd50;
      case (r_lfsr[1:0])
         2'd0:    w_scoreNext = 9'd50;
         2'd1:    w_scoreNext = 9'd100;
         2'd2:    w_scoreNext = 9'd150;
         default: w_scoreNext = 9'd300;
      endcase
   end

`ifdef MYSTERY_SHIP_RANDOM_WAIT_EN
   logic [15:0] r_waitTarget;
   assign w_waitTarget = r_waitTarget;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_waitTarget <= 16'(WAIT_FRAMES);
      else if (w_syncReset)
         r_waitTarget <= 16'(WAIT_FRAMES);
      else if (r_state != IDLE && w_nextState == IDLE)
         r_waitTarget <= 16'(WAIT_FRAMES) + {10'd0, r_lfsr[3:0], 2'b00};
   end
`else
   assign w_waitTarget = 16'(WAIT_FRAMES);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= IDLE;
      else if (w_syncReset)
         r_state <= IDLE;
      else
         r_state <= w_nextState;
   end

   // A hit takes priority over the exit step landing on the same cycle.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_waitDone) w_nextState = FLY;
         FLY:     if (w_hitDet) w_nextState = EXPLODE;
                  else if (w_exitStep) w_nextState = IDLE;
         EXPLODE: if (w_explodeDone) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_waitCnt <= '0; r_explodeCnt <= '0; r_divCnt <= '0;
         r_dir <= 1'b0; r_xPos <= X_FAR; r_hit <= 1'b0; r_score <= '0; r_lfsr <= 8'h01;
      end else if (w_syncReset) begin
         r_waitCnt <= '0; r_explodeCnt <= '0; r_divCnt <= '0;
         r_dir <= 1'b0; r_xPos <= X_FAR; r_hit <= 1'b0; r_score <= '0; r_lfsr <= 8'h01;
      end else begin
         r_hit <= 1'b0;
         if (w_tick) r_lfsr <= w_lfsrNext;
         case (r_state)
            IDLE: if (w_tick) begin
               if (w_waitDone) begin
                  r_waitCnt <= '0;
                  r_divCnt  <= '0;
                  r_xPos    <= r_dir ? '0 : X_FAR;
               end else
                  r_waitCnt <= r_waitCnt + 16'd1;
            end
            FLY: if (w_hitDet) begin
               r_hit    <= 1'b1;
               r_score  <= w_scoreNext;
               r_dir    <= ~r_dir;
               r_divCnt <= '0;
            end else if (w_tick) begin
               if (w_divWrap) begin
                  r_divCnt <= '0;
                  r_xPos   <= w_nextX;
                  if (w_exitStep) r_dir <= ~r_dir;
               end else
                  r_divCnt <= r_divCnt + 16'd1;
            end
            EXPLODE: if (w_tick) begin
               if (w_explodeDone) r_explodeCnt <= '0;
               else               r_explodeCnt <= r_explodeCnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.o_is_ship = 1'b0;
      bus.o_rgb     = 8'h00;
      case (r_state)
         FLY: begin
            bus.o_is_ship = w_scanInBox;
            if (w_scanInBox && w_visible) bus.o_rgb = COLOR_SHIP;
         end
         EXPLODE: begin
            bus.o_is_ship = w_scanInBox;
            if (w_scanInBox && w_visible) bus.o_rgb = COLOR_EXPLODE;
         end
         default: ;
      endcase
   end

   assign bus.o_hit         = r_hit;
   assign bus.o_score_value = r_score;
   assign bus.o_center_x    = r_xPos - X_WIDTH'(MARGIN);
   assign bus.o_center_y    = X_WIDTH'(SHIP_TOP + SHIP_HEIGHT / 2);
   assign bus.o_state       = r_state;
endmodule
